// File: rtl/audio_filter_pkg.sv
// rtl/audio_filter_pkg.sv - shared types and constants for the audio IIR filter
package audio_filter_pkg;

    typedef struct packed {
        logic [31:0] rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } flt_coef_t;

    localparam int CY_FRAC  = 21;
    localparam int CX_SHIFT = 8;
    localparam int Y_FRAC   = 16;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7fff;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_XSUM = 3'd1;
    localparam logic [2:0] S_XMUL = 3'd2;
    localparam logic [2:0] S_YMUL = 3'd3;
    localparam logic [2:0] S_ACC  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

endpackage

// File: rtl/audio_rate_gen.sv
// rtl/audio_rate_gen.sv - fractional accumulator producing the filter sample tick
module audio_rate_gen
    import audio_filter_pkg::*;
#(
    parameter int unsigned CLK_RATE = 48_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] flt_rate,
    output logic        tick
);

    logic [31:0] acc_q, acc_d;
    logic        tick_q, tick_d;
    logic [32:0] acc_n;

    always_comb begin
        acc_n  = {1'b0, acc_q} + {1'b0, flt_rate};
        acc_d  = acc_n[31:0];
        tick_d = 1'b0;
        // A rate at or above the clock saturates to one tick per cycle.
        if (flt_rate >= CLK_RATE) begin
            tick_d = 1'b1;
            acc_d  = '0;
        end else if (acc_n >= 33'(CLK_RATE)) begin
            tick_d = 1'b1;
            acc_d  = 32'(acc_n - 33'(CLK_RATE));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_iir_filter.sv
// rtl/audio_iir_filter.sv - stereo IIR low-pass engine with shadowed coefficients
module audio_iir_filter
    import audio_filter_pkg::*;
#(
    parameter int unsigned CLK_RATE = 48_000_000,
    parameter int          YW       = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        flt_rate,
    input  logic [39:0]        cx,
    input  logic [7:0]         cx0,
    input  logic [7:0]         cx1,
    input  logic [7:0]         cx2,
    input  logic [23:0]        cy0,
    input  logic [23:0]        cy1,
    input  logic [23:0]        cy2,
    input  logic               bypass,
    input  logic signed [15:0] sample_l,
    input  logic signed [15:0] sample_r,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int XW  = 26;
    localparam int XPW = XW + 40;
    localparam int YPW = YW + 26;

    flt_coef_t coef_in;
    assign coef_in = '{rate: flt_rate, cx: cx, cx0: cx0, cx1: cx1, cx2: cx2,
                       cy0: cy0, cy1: cy1, cy2: cy2};

    logic tick;

    audio_rate_gen #(.CLK_RATE(CLK_RATE)) u_rate_gen (
        .clk      (clk),
        .reset    (reset),
        .flt_rate (coef_in.rate),
        .tick     (tick)
    );

    logic [2:0]         state_q, state_d;
    logic               overrun_q, overrun_d;
    logic               byp_q, byp_d;
    logic [39:0]        cx_q, cx_d;
    logic [7:0]         cx0_q, cx0_d, cx1_q, cx1_d, cx2_q, cx2_d;
    logic signed [23:0] cy0_q, cy0_d, cy1_q, cy1_d, cy2_q, cy2_d;
    logic               take;

    always_comb begin
        take      = tick && (state_q == S_IDLE);
        overrun_d = overrun_q | (tick && (state_q != S_IDLE));
        byp_d     = byp_q;
        cx_d      = cx_q;
        cx0_d     = cx0_q;
        cx1_d     = cx1_q;
        cx2_d     = cx2_q;
        cy0_d     = cy0_q;
        cy1_d     = cy1_q;
        cy2_d     = cy2_q;
        if (take) begin
            byp_d = bypass;
            cx_d  = coef_in.cx;
            cx0_d = coef_in.cx0;
            cx1_d = coef_in.cx1;
            cx2_d = coef_in.cx2;
            cy0_d = $signed(coef_in.cy0);
            cy1_d = $signed(coef_in.cy1);
            cy2_d = $signed(coef_in.cy2);
        end
        case (state_q)
            S_IDLE:  state_d = take ? S_XSUM : S_IDLE;
            S_XSUM:  state_d = S_XMUL;
            S_XMUL:  state_d = S_YMUL;
            S_YMUL:  state_d = S_ACC;
            S_ACC:   state_d = S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            overrun_q <= 1'b0;
            byp_q     <= 1'b0;
            cx_q      <= '0;
            cx0_q     <= '0;
            cx1_q     <= '0;
            cx2_q     <= '0;
            cy0_q     <= '0;
            cy1_q     <= '0;
            cy2_q     <= '0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            byp_q     <= byp_d;
            cx_q      <= cx_d;
            cx0_q     <= cx0_d;
            cx1_q     <= cx1_d;
            cx2_q     <= cx2_d;
            cy0_q     <= cy0_d;
            cy1_q     <= cy1_d;
            cy2_q     <= cy2_d;
        end
    end

    logic signed [15:0] smp    [2];
    logic signed [15:0] ch_out [2];
    assign smp[0] = sample_l;
    assign smp[1] = sample_r;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic signed [15:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
        logic signed [XW-1:0] xs_q, xs_d;
        logic signed [YW-1:0] ff_q, ff_d, fb_q, fb_d;
        logic signed [YW-1:0] y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
        logic signed [YW-1:0] y0_c, yv_c;
        logic signed [15:0]   out_q, out_d;

        always_comb begin
            x0_d  = x0_q;
            x1_d  = x1_q;
            x2_d  = x2_q;
            x3_d  = x3_q;
            xs_d  = xs_q;
            ff_d  = ff_q;
            fb_d  = fb_q;
            y1_d  = y1_q;
            y2_d  = y2_q;
            y3_d  = y3_q;
            out_d = out_q;
            y0_c  = ff_q - fb_q;
            yv_c  = y0_c >>> Y_FRAC;
            case (state_q)
                S_IDLE: if (take) x0_d = smp[ch];
                S_XSUM: xs_d = XW'(x0_q)
                             + XW'($signed({1'b0, cx0_q})) * XW'(x1_q)
                             + XW'($signed({1'b0, cx1_q})) * XW'(x2_q)
                             + XW'($signed({1'b0, cx2_q})) * XW'(x3_q);
                S_XMUL: ff_d = YW'((XPW'(xs_q) * XPW'($signed({1'b0, cx_q}))) >>> CX_SHIFT);
                S_YMUL: fb_d = YW'((YPW'(cy0_q) * YPW'(y1_q)
                                  + YPW'(cy1_q) * YPW'(y2_q)
                                  + YPW'(cy2_q) * YPW'(y3_q)) >>> CY_FRAC);
                S_ACC: begin
                    x1_d = x0_q;
                    x2_d = x1_q;
                    x3_d = x2_q;
                    y1_d = y0_c;
                    y2_d = y1_q;
                    y3_d = y2_q;
                    if (byp_q)                      out_d = x0_q;
                    else if (yv_c > YW'(SAMPLE_MAX)) out_d = SAMPLE_MAX;
                    else if (yv_c < YW'(SAMPLE_MIN)) out_d = SAMPLE_MIN;
                    else                            out_d = 16'(yv_c);
                end
                default: ;
            endcase
            // Histories stay cleared for any bypassed sample so filtering resumes from rest.
            if (bypass || (byp_q && state_q == S_ACC)) begin
                x1_d = '0;
                x2_d = '0;
                x3_d = '0;
                y1_d = '0;
                y2_d = '0;
                y3_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                x0_q  <= '0;
                x1_q  <= '0;
                x2_q  <= '0;
                x3_q  <= '0;
                xs_q  <= '0;
                ff_q  <= '0;
                fb_q  <= '0;
                y1_q  <= '0;
                y2_q  <= '0;
                y3_q  <= '0;
                out_q <= '0;
            end else begin
                x0_q  <= x0_d;
                x1_q  <= x1_d;
                x2_q  <= x2_d;
                x3_q  <= x3_d;
                xs_q  <= xs_d;
                ff_q  <= ff_d;
                fb_q  <= fb_d;
                y1_q  <= y1_d;
                y2_q  <= y2_d;
                y3_q  <= y3_d;
                out_q <= out_d;
            end
        end

        assign ch_out[ch] = out_q;
    end

    assign out_l     = ch_out[0];
    assign out_r     = ch_out[1];
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: doc/audio_iir_filter.md
# audio_iir_filter

Runtime IIR low-pass engine that consumes the coefficient set (rate, gain, three X-tap scales, three Y-tap feedback terms) selected by the audio filter-switch coefficient ROM. It filters a stereo 16-bit PCM stream at the coefficient-specified sampling rate, using zero-order-hold oversampling of the input. It sits between the core's sound mixer and the Pocket I2S serializer. It is the consumer end of the coefficient interface.

## Interface
- `CLK_RATE`, 48_000_000: frequency of `clk` in Hz; used by the fractional tick generator.
- `YW`, 48: width of the internal signed Y history registers, in Q(YW-16).16 format.
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous reset, active-high.
- `flt_rate` in 32: filter sampling frequency in Hz. 0 stops processing.
- `cx` in 40: unsigned X gain.
- `cx0`, `cx1`, `cx2` in 8 each: unsigned scales for X taps x[n-1], x[n-2], x[n-3].
- `cy0`, `cy1`, `cy2` in 24 each: signed Q3.21 feedback terms for y[n-1], y[n-2], y[n-3].
- `bypass` in 1: passes input straight through and clears the histories.
- `sample_l`, `sample_r` in 16 each: signed input PCM, held by the source.
- `out_l`, `out_r` out 16 each: signed filtered PCM.
- `out_valid` out 1: one-cycle pulse when `out_l`/`out_r` update.
- `busy` out 1: computation in progress.
- `overrun` out 1: sticky; a tick arrived while busy. Cleared only by `reset`.

## Operation
- **Tick generator:**
  - Each cycle: `acc_n = acc + flt_rate`. If `acc_n >= CLK_RATE`, assert `tick` and set `acc = acc_n - CLK_RATE`; otherwise set `acc = acc_n`.
  - If `flt_rate >= CLK_RATE`, `tick` asserts every cycle and `acc` is forced to 0.
  - If `flt_rate == 0`, there are no ticks and the outputs hold.
- **FSM states:** IDLE → XSUM → XMUL → YMUL → ACC → OUT → IDLE. Both channels are computed in parallel, with identical logic per channel.
- **IDLE:** on `tick`, snapshot all coefficients and both inputs into shadow registers. Coefficient changes mid-computation therefore do not affect the sample in flight.
- **XSUM:** compute `xs = x0 + cx0*x1 + cx1*x2 + cx2*x3`, 26-bit signed, where x0 is the snapshot input.
- **XMUL:** compute `ff = (xs * cx) >>> 8` (arithmetic shift), truncated to YW bits. With `cx = 2^24` the X path has unity gain.
- **YMUL:** compute `fb = (cy0*y1 + cy1*y2 + cy2*y3) >>> 21`, using full-width products and sum (74 bits), then truncated to YW.
- **ACC:** compute `y0 = ff - fb`, wrapping to YW bits. Then shift the histories: x3←x2, x2←x1, x1←x0 and y3←y2, y2←y1, y1←y0.
- **OUT:**
  - `out = y0 >>> 16`, saturated to [-32768, 32767].
  - Pulse `out_valid`.
- **Overrun:** a `tick` while the FSM is not in IDLE is dropped and sets `overrun`.
- **Bypass:**
  - While `bypass=1`, every tick produces `out = input` through the same state sequence with unchanged latency.
  - All x/y histories are held at 0.
  - Deasserting `bypass` restarts filtering from zero history.
- **Reset:**
  - `reset` mid-computation returns the FSM to IDLE immediately and discards the pending sample.
  - Reset values: `out_l=out_r=0`, `out_valid=0`, `busy=0`, `overrun=0`, `acc=0`, all histories 0.

## Timing
- `tick` is registered in cycle T.
- `busy` is high in cycles T+1..T+5.
- `out_l`/`out_r` update and `out_valid` is high in cycle T+5 only.
- The minimum tick spacing without overrun is 6 cycles, so `flt_rate <= CLK_RATE/6`. The default 7.056 MHz rate at 48 MHz spaces ticks 6–7 cycles apart.
- A tick in the same cycle as OUT is an overrun. A tick in the first IDLE cycle after OUT is accepted.
- `reset` takes priority over `tick` in the same cycle.

## Structure
- Shared package `audio_filter_pkg`:
  - typedef `flt_coef_t`, a packed struct of rate, cx, cx0..2, cy0..2 with the widths above.
  - constants `CY_FRAC=21`, `CX_SHIFT=8`, `Y_FRAC=16`, `SAMPLE_MAX`, `SAMPLE_MIN`.
- Sub-module `audio_rate_gen` holds the fractional tick accumulator. Inputs: `clk`, `reset`, `flt_rate`. Output: `tick`.
- The top level contains the FSM, the shadow registers, and a per-channel datapath generated twice.

## Test plan
- **Tick rate:** `CLK_RATE=48e6`, `flt_rate=7056000`, run 1,000,000 cycles → exactly 147,000 `out_valid` pulses, `overrun=0`.
- **Unity passthrough:** `cx=2^24`, `cx0..2=0`, `cy*=0`, `sample_l=1234`, `sample_r=-500` → every output equals the input; `out_valid` arrives 5 cycles after each tick.
- **One-pole step:** `cx=2^24`, `cy0=-1048576`, others 0, step `sample_l` from 0 to 1000 → successive `out_l` values are 1000, 1500, 1750, 1875, 1937.
- **Saturation:** `cx=2^25`, `sample_l=20000` → `out_l=32767`; `sample_r=-20000` → `out_r=-32768`.
- **Overrun:** `flt_rate=CLK_RATE/3` → `overrun` sets after the second tick and stays set. A `reset` pulse clears it and zeroes all outputs.
- **Coefficient and bypass robustness:** changing `cy0` in the cycle after a tick does not alter that sample's output. Asserting `bypass` mid-stream gives output = input on the next tick. Deasserting it restarts the filter from zero history, so the first output equals the one-pole step's first value.
